// File: rtl/coherent_averager.sv
// rtl/coherent_averager.sv - sums 2^K_LOG2 periods of M samples point-by-point and streams the averaged period
module coherent_averager #(
    parameter int M      = 16,
    parameter int K_LOG2 = 4,
    parameter int ACC_W  = 32 + K_LOG2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        data_valid,
    input  logic [31:0] data,
    output logic        avg_valid,
    output logic [31:0] avg_data,
    output logic        avg_sop,
    output logic        avg_eop,
    output logic        busy,
    output logic        overrun
);

    localparam int IDX_W = $clog2(M);
    localparam int PER_W = (K_LOG2 > 0) ? K_LOG2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'((1 << K_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DUMP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]        r_idx;
    logic [PER_W-1:0]        r_per;
    logic [ACC_W-1:0]        r_acc [M];

    logic                    w_acc_we;
    logic                    w_rd_en;
    logic                    w_drop;
    logic                    w_last_smp;
    logic signed [ACC_W-1:0] w_acc_rd;
    logic signed [ACC_W-1:0] w_data_ext;
    logic        [ACC_W-1:0] w_acc_sum;
    logic        [31:0]      w_avg;

    assign w_last_smp = (r_idx == IDX_LAST) && (r_per == PER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (data_valid && w_last_smp) begin
                    w_next = S_DUMP;
                end
            end
            S_DUMP: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (r_idx == IDX_LAST) begin
                    w_next = S_ACCUM;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_acc_we = 1'b0;
        w_rd_en  = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            S_ACCUM: w_acc_we = enable && data_valid;
            S_DUMP: begin
                w_rd_en = enable;
                w_drop  = data_valid;
            end
            default: begin
                w_acc_we = 1'b0;
                w_rd_en  = 1'b0;
                w_drop   = 1'b0;
            end
        endcase
    end

    // idx doubles as the accumulate address and the dump read address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_per <= '0;
        end else if (r_state == S_IDLE || !enable) begin
            r_idx <= '0;
            r_per <= '0;
        end else if (w_acc_we) begin
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
                r_per <= (r_per == PER_LAST) ? '0 : r_per + PER_W'(1);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else if (w_rd_en) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign w_acc_rd   = r_acc[r_idx];
    assign w_data_ext = ACC_W'($signed(data));
    // first period overwrites, so the RAM never needs an explicit clear
    assign w_acc_sum  = ((r_per == '0) ? '0 : w_acc_rd) + w_data_ext;
    assign w_avg      = 32'(w_acc_rd >>> K_LOG2);

    always_ff @(posedge clk) begin
        if (w_acc_we) begin
            r_acc[r_idx] <= w_acc_sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avg_valid <= 1'b0;
            avg_data  <= '0;
            avg_sop   <= 1'b0;
            avg_eop   <= 1'b0;
        end else if (w_rd_en) begin
            avg_valid <= 1'b1;
            avg_data  <= w_avg;
            avg_sop   <= (r_idx == '0);
            avg_eop   <= (r_idx == IDX_LAST);
        end else begin
            avg_valid <= 1'b0;
            avg_data  <= '0;
            avg_sop   <= 1'b0;
            avg_eop   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy <= (r_state != S_IDLE);
            if (!enable) begin
                overrun <= 1'b0;
            end else if (w_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coherent_averager.sv
// tb/tb_coherent_averager.sv - directed self-checking bench for coherent_averager (M=16, K_LOG2=2)
module tb_coherent_averager;

    localparam int M      = 16;
    localparam int K_LOG2 = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        data_valid;
    logic [31:0] data;
    logic        avg_valid;
    logic [31:0] avg_data;
    logic        avg_sop;
    logic        avg_eop;
    logic        busy;
    logic        overrun;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        int          t;
    } word_t;

    word_t       q[$];
    int          neg_cnt   = 0;
    int          last_dv   = 0;
    int          zero_viol = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    logic [31:0] exp_w [M];

    coherent_averager #(.M(M), .K_LOG2(K_LOG2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .data_valid(data_valid),
        .data      (data),
        .avg_valid (avg_valid),
        .avg_data  (avg_data),
        .avg_sop   (avg_sop),
        .avg_eop   (avg_eop),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        word_t w;
        neg_cnt++;
        if (data_valid) last_dv = neg_cnt;
        if (avg_valid) begin
            w.d   = avg_data;
            w.sop = avg_sop;
            w.eop = avg_eop;
            w.t   = neg_cnt;
            q.push_back(w);
        end else if (avg_data != 32'd0 || avg_sop || avg_eop) begin
            zero_viol++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        data       = v;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        step();
        step();
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (3) step();
        q.delete();
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            step();
            k++;
        end
        repeat (3) step();
        check_eq({tag, "_count"}, q.size(), n);
    endtask

    task automatic check_frame(input string tag, input int off);
        int nsop = 0;
        int neop = 0;
        if (q.size() >= off + M) begin
            for (int i = 0; i < M; i++) begin
                check_eq($sformatf("%s_w%0d", tag, i), q[off+i].d, exp_w[i]);
                if (q[off+i].sop) nsop++;
                if (q[off+i].eop) neop++;
            end
            check_eq({tag, "_sop0"}, q[off].sop, 1);
            check_eq({tag, "_eop15"}, q[off+M-1].eop, 1);
            check_eq({tag, "_nsop"}, nsop, 1);
            check_eq({tag, "_neop"}, neop, 1);
        end
    endtask

    function automatic logic [31:0] signed_vec(input int p, input int j);
        case (j)
            0:       return (p < 3) ? 32'hFFFF_FFFF : 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFF8;
            3:       return (p == 0) ? 32'd5 : 32'd0;
            4:       return (p == 0) ? 32'hFFFF_FFFB : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        int contig;
        reset_n    = 1'b0;
        enable     = 1'b0;
        data_valid = 1'b0;
        data       = '0;
        repeat (3) step();
        check_eq("rst_valid", avg_valid, 0);
        check_eq("rst_data", avg_data, 0);
        check_eq("rst_sop_eop", {avg_sop, avg_eop}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        step();

        // constant 100, one sample every 33 cycles
        start_run();
        check_eq("const_busy", busy, 1);
        for (int i = 0; i < 4 * M; i++) begin
            send(32'd100);
            repeat (32) step();
        end
        wait_words("const", M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'd100;
        check_frame("const", 0);
        check_eq("const_overrun", overrun, 0);
        stop_run();

        // ramp, back-to-back samples
        start_run();
        for (int i = 0; i < 4 * M; i++) send(32'(i % M));
        wait_words("ramp", M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'(i);
        check_frame("ramp", 0);
        if (q.size() >= M) begin
            check_eq("ramp_latency", q[0].t, last_dv + 2);
            contig = 0;
            for (int i = 1; i < M; i++) if (q[i].t != q[0].t + i) contig++;
            check_eq("ramp_contig", contig, 0);
        end
        stop_run();

        // signed rounding and full-scale positive
        start_run();
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < M; j++) send(signed_vec(p, j));
        wait_words("sgn", M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'd0;
        exp_w[0] = 32'hFFFF_FFFF;
        exp_w[1] = 32'h7FFF_FFFF;
        exp_w[2] = 32'hFFFF_FFF8;
        exp_w[3] = 32'd1;
        exp_w[4] = 32'hFFFF_FFFE;
        check_frame("sgn", 0);
        stop_run();

        // back-to-back frames: 16 samples dropped during each dump
        start_run();
        for (int n = 0; n < 4 * M + M + 4 * M; n++) send(32'(n));
        wait_words("b2b", 2 * M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'(i + 24);
        check_frame("b2b_f1", 0);
        for (int i = 0; i < M; i++) exp_w[i] = 32'(i + 104);
        check_frame("b2b_f2", M);
        check_eq("b2b_overrun_set", overrun, 1);
        enable = 1'b0;
        step();
        step();
        check_eq("b2b_overrun_clr", overrun, 0);
        stop_run();

        // abort mid-frame, then a clean frame of 7
        start_run();
        for (int i = 0; i < 30; i++) send(32'd999);
        check_eq("abort_busy_pre", busy, 1);
        enable = 1'b0;
        step();
        step();
        check_eq("abort_busy_post", busy, 0);
        repeat (20) step();
        check_eq("abort_no_words", q.size(), 0);
        start_run();
        for (int i = 0; i < 4 * M; i++) send(32'd7);
        wait_words("reen", M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'd7;
        check_frame("reen", 0);
        stop_run();

        // asynchronous reset while word 5 is on the output
        start_run();
        for (int i = 0; i < 4 * M; i++) send(32'(50 + i % M));
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        check_eq("rdump_valid", avg_valid, 0);
        check_eq("rdump_data", avg_data, 0);
        check_eq("rdump_busy", busy, 0);
        repeat (3) step();
        check_eq("rdump_words", q.size(), 5);
        q.delete();
        enable  = 1'b1;
        reset_n = 1'b1;
        step();
        step();
        for (int i = 0; i < 4 * M; i++) send(32'(20 + i % M));
        wait_words("rpost", M, 40);
        for (int i = 0; i < M; i++) exp_w[i] = 32'(20 + i);
        check_frame("rpost", 0);
        stop_run();

        check_eq("idle_outputs_zero", zero_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coherent_averager.md
# coherent_averager

Downstream consumer of the sample stream produced by the periodic data source. It sums K = 2^K_LOG2 consecutive periods of M samples point-by-point into an accumulator RAM. It then emits one averaged period of M words as a framed stream. The block is the first stage of the SSVEP coherent-averaging path and feeds the per-period analysis stages.

## Interface
Parameters:
- M, 16: samples per period; accumulator depth; ≥2.
- K_LOG2, 4: log2 of the number of periods averaged per frame; 0..8.
- ACC_W, 32+K_LOG2: accumulator word width in bits. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run control. High: acquire frames back-to-back. Low: abort and idle.
- data_valid  in  1  one-cycle strobe qualifying data; may be asserted on consecutive cycles.
- data  in  32  input sample, two's-complement signed.
- avg_valid  out  1  averaged-word strobe.
- avg_data  out  32  averaged sample, signed.
- avg_sop  out  1  high with avg_valid on word 0 of a frame.
- avg_eop  out  1  high with avg_valid on word M-1 of a frame.
- busy  out  1  high in ACCUM or DUMP.
- overrun  out  1  sticky flag: a data_valid arrived during DUMP and was dropped.

## Operation
- State machine with three states: IDLE, ACCUM, DUMP.
  - IDLE -> ACCUM: on a cycle with enable=1. The transition clears idx (sample index 0..M-1) and per (period index 0..K-1).
  - ACCUM, each cycle with data_valid=1:
    - acc[idx] <= (per==0 ? 0 : acc[idx]) + sign_extend(data, ACC_W).
    - idx increments; at M-1 it wraps to 0 and per increments.
    - When the accepted sample has idx=M-1 and per=K-1, the state goes to DUMP.
  - DUMP: reads acc[0..M-1] in order, one word per cycle, with no gaps.
    - avg_data = acc[j] >>> K_LOG2 (arithmetic shift, truncation toward −∞), low 32 bits.
    - After word M-1 is issued, the next state is ACCUM (if enable=1, with idx and per cleared) or IDLE.
- The per==0 overwrite means the RAM never needs clearing; stale contents are never visible.
- enable=0 in ACCUM or DUMP:
  - Next state is IDLE.
  - A partial frame is discarded; no further avg_valid is issued, including the remainder of a DUMP.
  - overrun is cleared.
- data_valid in IDLE: ignored. data_valid in DUMP: dropped and sets overrun. overrun clears only on reset or when enable=0.
- Arithmetic: the sum of K 32-bit signed values fits ACC_W exactly, so there is no saturation or wrap.
- Reset (asynchronous, any time): state=IDLE, idx=0, per=0, and every output = 0. Accumulator RAM contents are not reset. A frame interrupted by reset is lost.

## Timing
- Accumulation is single-cycle read-modify-write. A sample at cycle t is complete in acc before a sample at t+1 reads the same address. Since M≥2, consecutive samples never target the same address.
- If the final sample of a frame is accepted at cycle t:
  - State is DUMP from t+1.
  - avg_valid is high on cycles t+2 .. t+M+1. The RAM read is registered, giving 2-cycle latency.
  - avg_sop is high at t+2; avg_eop is high at t+M+1.
- With enable held high, the next frame may accept samples from cycle t+M+1 onward. Samples at t+1 .. t+M are dropped and set overrun.
- busy is registered and tracks the state: high from the cycle after the IDLE exit until the cycle after the return to IDLE.
- avg_data, avg_sop and avg_eop are 0 whenever avg_valid=0.

## Test plan
- Constant input: M=16, K_LOG2=2, data=100 every 33 cycles for 64 samples -> 16 avg_valid words, all 100; avg_sop on the first word, avg_eop on the 16th; overrun=0.
- Ramp input: sample value = idx (0..15) repeated 4 periods, data_valid every cycle -> outputs 0,1,…,15; first avg_valid exactly 2 cycles after the last input; the 16 words are contiguous.
- Signed rounding: K_LOG2=2, position 0 receives −1, −1, −1, 0 -> avg_data[0] = −1 (sum −3 >>> 2); position 1 receives 0x7FFFFFFF ×4 -> 0x7FFFFFFF with no overflow.
- Back-to-back with overrun: data_valid every cycle, enable held high -> 16 samples during each DUMP dropped and overrun=1. The next frame's results match samples taken only after the dump; deasserting enable clears overrun.
- Abort: enable drops after 30 of 64 samples -> no avg_valid and busy=0 two cycles later. Re-enable and feed a full frame of constant 7 -> outputs all 7; no stale data from the aborted frame.
- Reset mid-DUMP: assert reset_n=0 at output word 5 -> all outputs 0 immediately (asynchronous). After release with enable=1, the next full frame is output correctly from word 0.
